// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
//   Shared constants for the seven-segment score display.
//   - SEG_0..SEG_7 : active-low glyph codes for the decimal digits 0..7,
//                    packed g..a (bit6 = g, bit0 = a).
//   - A..G         : bit index of each segment inside a 7-bit code.
// -----------------------------------------------------------------------------
package display_pkg;

    // Segment bit positions inside a 7-bit code.
    localparam int unsigned A = 0;
    localparam int unsigned B = 1;
    localparam int unsigned C = 2;
    localparam int unsigned D = 3;
    localparam int unsigned E = 4;
    localparam int unsigned F = 5;
    localparam int unsigned G = 6;

    localparam int unsigned SEG_W = 7;

    // Active-low glyphs: a 0 bit lights the segment.
    localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h78;

endpackage : display_pkg

// File: rtl/display_seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
//   Purely combinational digit decoder. Maps a 3-bit score to the active-low
//   seven-segment glyph of its decimal value.
//   Ports:
//     in   [2:0] : score value 0..7 (every code is legal)
//     code [6:0] : active-low glyph, bit0 = a .. bit6 = g
// -----------------------------------------------------------------------------
module seg7_decode
    import display_pkg::*;
(
    input  logic [2:0]       in,
    output logic [SEG_W-1:0] code
);

    always_comb begin
        // Default keeps the block latch-free; every value is overwritten below.
        code = SEG_0;
        case (in)
            3'd0: code = SEG_0;
            3'd1: code = SEG_1;
            3'd2: code = SEG_2;
            3'd3: code = SEG_3;
            3'd4: code = SEG_4;
            3'd5: code = SEG_5;
            3'd6: code = SEG_6;
            3'd7: code = SEG_7;
            default: code = SEG_0;
        endcase
    end

endmodule : seg7_decode

// File: rtl/display.sv
// -----------------------------------------------------------------------------
// display
//   Registered seven-segment score display. The score on `in` is decoded,
//   adjusted to the panel polarity and captured on every rising clk edge, so
//   `out` shows the glyph one cycle after `in` changes and never glitches
//   between edges.
//   There is no handshake: `in` is treated as always valid and is sampled on
//   every rising edge; there is no ready/back-pressure path.
//   Parameters:
//     ACTIVE_LOW : 1 -> segment lit when its bit is 0; 0 -> lit when bit is 1
//   Ports:
//     clk        : clock, rising edge
//     reset      : synchronous, active-high; loads glyph "0", wins over `in`
//     in   [2:0] : score value 0..7
//     out  [6:0] : segment drive, bit0 = a .. bit6 = g
// -----------------------------------------------------------------------------
module display
    import display_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       in,
    output logic [SEG_W-1:0] out
);

    logic [SEG_W-1:0] code_al;
    logic [SEG_W-1:0] code_pol;
    logic [SEG_W-1:0] reset_glyph;

    seg7_decode u_decode (
        .in   (in),
        .code (code_al)
    );

    // The decoder always speaks active-low; flip here for active-high panels.
    assign code_pol    = ACTIVE_LOW ? code_al : ~code_al;
    assign reset_glyph = ACTIVE_LOW ? SEG_0   : ~SEG_0;

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= reset_glyph;
        end else begin
            out <= code_pol;
        end
    end

endmodule : display

// File: tb/tb_display.sv
// -----------------------------------------------------------------------------
// tb_display
//   Directed bench for display. Two instances share clk/reset/in: one with
//   the default active-low polarity, one with ACTIVE_LOW = 0.
// -----------------------------------------------------------------------------
module tb_display;

    logic       clk;
    logic       reset;
    logic [2:0] in;
    logic [6:0] out_lo;
    logic [6:0] out_hi;

    int vectors = 0;
    int miscompares = 0;

    // Hand-written glyph tables, digits 0..7.
    logic [6:0] glyph_lo [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    logic [6:0] glyph_hi [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};

    // Scoreboard of expected active-low outputs for the streaming test.
    logic [6:0] exp_q [$];

    display u_dut_lo (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .out   (out_lo)
    );

    display #(.ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .out   (out_hi)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        reset = 1'b1;
        in    = 3'd0;
    end

    // ---------------- driver ----------------
    // Drive on the falling edge, then return 1 time unit after the next
    // rising edge so outputs are sampled away from the active edge.
    task automatic apply(input logic rst, input logic [2:0] v);
        @(negedge clk);
        reset = rst;
        in    = v;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply(1'b1, 3'd3);
        vectors++;
        if (out_lo !== 7'h40) begin
            miscompares++;
            $display("FAIL reset_lo: got %h expected %h", out_lo, 7'h40);
        end
        vectors++;
        if (out_hi !== 7'h3F) begin
            miscompares++;
            $display("FAIL reset_hi: got %h expected %h", out_hi, 7'h3F);
        end
    endtask

    task automatic test_sequence();
        logic [6:0] exp;
        for (int v = 0; v < 8; v++) begin
            exp_q.push_back(glyph_lo[v]);
            apply(1'b0, 3'(v));
            exp = exp_q.pop_front();
            vectors++;
            if (out_lo !== exp) begin
                miscompares++;
                $display("FAIL seq_lo[%0d]: got %h expected %h", v, out_lo, exp);
            end
            vectors++;
            if (out_hi !== glyph_hi[v]) begin
                miscompares++;
                $display("FAIL seq_hi[%0d]: got %h expected %h", v, out_hi, glyph_hi[v]);
            end
        end
    endtask

    task automatic test_hold();
        for (int c = 0; c < 4; c++) begin
            apply(1'b0, 3'd5);
            vectors++;
            if (out_lo !== 7'h12) begin
                miscompares++;
                $display("FAIL hold_edge[%0d]: got %h expected %h", c, out_lo, 7'h12);
            end
            // Mid-cycle sample: must not have moved between edges.
            #3;
            vectors++;
            if (out_lo !== 7'h12) begin
                miscompares++;
                $display("FAIL hold_mid[%0d]: got %h expected %h", c, out_lo, 7'h12);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply(1'b0, 3'd6);
        vectors++;
        if (out_lo !== 7'h02) begin
            miscompares++;
            $display("FAIL rmid_pre: got %h expected %h", out_lo, 7'h02);
        end
        apply(1'b1, 3'd6);
        vectors++;
        if (out_lo !== 7'h40) begin
            miscompares++;
            $display("FAIL rmid_reset: got %h expected %h", out_lo, 7'h40);
        end
        apply(1'b0, 3'd6);
        vectors++;
        if (out_lo !== 7'h02) begin
            miscompares++;
            $display("FAIL rmid_release: got %h expected %h", out_lo, 7'h02);
        end
    endtask

    task automatic test_active_high();
        apply(1'b0, 3'd1);
        vectors++;
        if (out_hi !== 7'h06) begin
            miscompares++;
            $display("FAIL ah_in1: got %h expected %h", out_hi, 7'h06);
        end
        apply(1'b0, 3'd7);
        vectors++;
        if (out_hi !== 7'h07) begin
            miscompares++;
            $display("FAIL ah_in7: got %h expected %h", out_hi, 7'h07);
        end
        apply(1'b1, 3'd7);
        vectors++;
        if (out_hi !== 7'h3F) begin
            miscompares++;
            $display("FAIL ah_reset: got %h expected %h", out_hi, 7'h3F);
        end
    endtask

    task automatic test_wrap();
        apply(1'b0, 3'd7);
        vectors++;
        if (out_lo !== 7'h78) begin
            miscompares++;
            $display("FAIL wrap_7: got %h expected %h", out_lo, 7'h78);
        end
        // Change in, then confirm out waits for the next rising edge.
        @(negedge clk);
        in = 3'd0;
        #1;
        vectors++;
        if (out_lo !== 7'h78) begin
            miscompares++;
            $display("FAIL wrap_latency: got %h expected %h", out_lo, 7'h78);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (out_lo !== 7'h40) begin
            miscompares++;
            $display("FAIL wrap_0: got %h expected %h", out_lo, 7'h40);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] pat [6] = '{3'd2, 3'd4, 3'd1, 3'd7, 3'd3, 3'd6};
        for (int i = 0; i < 6; i++) begin
            apply(1'b0, pat[i]);
            vectors++;
            if (out_lo !== glyph_lo[pat[i]]) begin
                miscompares++;
                $display("FAIL b2b[%0d]: got %h expected %h", i, out_lo, glyph_lo[pat[i]]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_sequence();
        test_hold();
        test_reset_mid();
        test_active_high();
        test_wrap();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_display
